// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// request kinds and the per-transaction record latched at acceptance.
package dmem_responder_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 32;
    localparam int DEFAULT_WAIT_STATES = 2;
    localparam int WAIT_CNT_W          = 4;   // holds the largest legal WAIT_STATES (15)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    typedef struct packed {
        req_type_t   kind;
        logic        reject;
        logic [31:0] wdata;
    } req_info_t;

    // A request is refused when both strobes are set, the address is not
    // word aligned, or the word index lies beyond the storage array.
    function automatic logic is_rejected(input logic        rd,
                                         input logic        wr,
                                         input logic [31:0] addr,
                                         input logic [31:0] depth_words);
        return (rd & wr)
             | (addr[1:0] != 2'b00)
             | ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor-side data-memory bus: request strobes, address and store data
// toward the responder; load data and the ready/busy/err status back.
interface dmem_responder_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, ready, busy, err
    );

endinterface

// File: rtl/dmem_wait_counter.sv
// Wait-state down-counter: loaded on request acceptance, decremented while the
// responder waits, flagging the cycle in which the count runs out.
module dmem_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // High when the count is at zero or reaches zero on this decrement, so the
    // responder can leave WAIT exactly as the count expires.
    assign o_zero = (r_count <= WIDTH'(1));

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access,
// answering one load or store at a time with a single-cycle ready pulse.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int                    IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0]           DEPTH_LIMIT = 32'(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD   = WAIT_CNT_W'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("dmem_responder: WAIT_STATES must lie in 0..15");
    end

    state_t           r_state;
    state_t           w_next_state;
    req_info_t        r_req;
    req_info_t        w_in_req;
    req_info_t        w_cur_req;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_in_idx;
    logic [IDX_W-1:0] w_cur_idx;
    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [31:0]      r_read_data;
    logic             w_req_strobe;
    logic             w_accept;
    logic             w_enter_resp;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;

    // Incoming request, decoded every cycle but only latched on acceptance.
    assign w_req_strobe = bus.mem_read | bus.mem_write;
    assign w_in_idx     = bus.addr[IDX_W+1:2];

    always_comb begin
        w_in_req.kind   = bus.mem_write ? REQ_WRITE : REQ_READ;
        w_in_req.reject = is_rejected(bus.mem_read, bus.mem_write, bus.addr, DEPTH_LIMIT);
        w_in_req.wdata  = bus.write_data;
    end

    // With zero wait states RESP is entered on the accepting edge itself, so
    // the access must use the live request rather than the not-yet-latched one.
    assign w_cur_req = (r_state == ST_IDLE) ? w_in_req : r_req;
    assign w_cur_idx = (r_state == ST_IDLE) ? w_in_idx : r_idx;

    dmem_wait_counter #(
        .WIDTH        (WAIT_CNT_W)
    ) u_wait_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_cnt_load),
        .i_dec        (w_cnt_dec),
        .i_load_value (WAIT_LOAD),
        .o_zero       (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_strobe) begin
                    w_accept     = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_req <= w_in_req;
            r_idx <= w_in_idx;
        end
    end

    // The access happens on the edge into RESP so load data is already valid
    // while ready is high; a rejected request touches neither array nor data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array is cleared by reset, which forces a flop-based
            // implementation rather than a RAM macro.
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_read_data <= '0;
        end else if (w_enter_resp && !w_cur_req.reject) begin
            if (w_cur_req.kind == REQ_WRITE) begin
                r_mem[w_cur_idx] <= w_cur_req.wdata;
            end else begin
                r_read_data <= r_mem[w_cur_idx];
            end
        end
    end

    assign bus.ready     = (r_state == ST_RESP);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.err       = (r_state == ST_RESP) & r_req.reject;
    assign bus.read_data = r_read_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a directed vector table, hand-written multi-cycle
// sequences and randomized traffic scored against an array-based memory model.
module tb_dmem_responder;

    localparam int WS_MAIN = 2;
    localparam int DEPTH   = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        tb_rd;
    logic        tb_wr;
    logic [31:0] tb_addr;
    logic [31:0] tb_wdata;

    always #5 clk = ~clk;

    dmem_responder_if bus_main ();
    dmem_responder_if bus_zero ();

    assign bus_main.mem_read   = tb_rd & ~sel;
    assign bus_main.mem_write  = tb_wr & ~sel;
    assign bus_main.addr       = tb_addr;
    assign bus_main.write_data = tb_wdata;
    assign bus_zero.mem_read   = tb_rd & sel;
    assign bus_zero.mem_write  = tb_wr & sel;
    assign bus_zero.addr       = tb_addr;
    assign bus_zero.write_data = tb_wdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_MAIN)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_main)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_zero (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_zero)
    );

    logic        w_ready;
    logic        w_busy;
    logic        w_err;
    logic [31:0] w_rdata;
    assign w_ready = sel ? bus_zero.ready     : bus_main.ready;
    assign w_busy  = sel ? bus_zero.busy      : bus_main.busy;
    assign w_err   = sel ? bus_zero.err       : bus_main.err;
    assign w_rdata = sel ? bus_zero.read_data : bus_main.read_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_rd = 32'h0;
    endtask

    // Memory semantics from first principles: byte address / 4 selects a word.
    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, output logic exp_err,
                               output logic [31:0] exp_rd);
        exp_err = (rd && wr) || (a % 4 != 0) || (a / 4 >= DEPTH);
        if (!exp_err) begin
            if (wr) model_mem[a / 4] = d;
            else    model_rd = model_mem[a / 4];
        end
        exp_rd = model_rd;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after ready.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output logic e, output logic [31:0] rdata,
                          output int lat, output logic busy_bad, output logic post_active);
        tb_rd = rd; tb_wr = wr; tb_addr = a; tb_wdata = d;
        @(posedge clk);
        #1;
        tb_rd = 1'b0; tb_wr = 1'b0;
        lat = 0;
        busy_bad = 1'b0;
        @(negedge clk);
        while (!w_ready && lat < 40) begin
            if (!w_busy || w_err) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!w_busy) busy_bad = 1'b1;
        e = w_err;
        rdata = w_rdata;
        @(negedge clk);
        post_active = w_ready | w_busy | w_err;
    endtask

    task automatic run_and_check(input string name, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic exp_err, input logic [31:0] exp_rd);
        logic        e;
        logic [31:0] r;
        int          lat;
        logic        busy_bad;
        logic        post_active;
        do_txn(rd, wr, a, d, e, r, lat, busy_bad, post_active);
        check({name, " err"}, 32'(e), 32'(exp_err));
        check({name, " read_data"}, r, exp_rd);
        check({name, " latency"}, 32'(lat), sel ? 32'd0 : 32'(WS_MAIN));
        check({name, " busy in flight"}, 32'(busy_bad), 32'd0);
        check({name, " idle after ready"}, 32'(post_active), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        exp_err;
        logic [31:0] exp_rd;
        int          ready_count;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_000C, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_007C, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_000D, 32'h1234_5678, 1'b1, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

        sel = 1'b0; tb_rd = 1'b0; tb_wr = 1'b0; tb_addr = '0; tb_wdata = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset ready", 32'(bus_main.ready), 32'd0);
        check("reset busy", 32'(bus_main.busy), 32'd0);
        check("reset err", 32'(bus_main.err), 32'd0);
        check("reset read_data", bus_main.read_data, 32'd0);

        // First vector is presented in the very first cycle out of reset.
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp_err, exp_rd);
            run_and_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                          vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rd);
        end

        // A load strobed while a store waits must be dropped, not queued.
        tb_wr = 1'b1; tb_addr = 32'h10; tb_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        tb_wr = 1'b0;
        model_apply(1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, exp_err, exp_rd);
        ready_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (w_ready) ready_count++;
            if (i == 0) begin tb_rd = 1'b1; tb_addr = 32'h10; end
            if (i == 2) tb_rd = 1'b0;
        end
        check("ignored strobe ready count", 32'(ready_count), 32'd1);
        check("ignored strobe busy after", 32'(w_busy), 32'd0);
        check("ignored strobe read_data", w_rdata, model_rd);
        model_apply(1'b1, 1'b0, 32'h10, 32'h0, exp_err, exp_rd);
        run_and_check("load after ignored", 1'b1, 1'b0, 32'h10, 32'h0, exp_err, exp_rd);

        // Reset during WAIT aborts the store and wipes every word.
        tb_wr = 1'b1; tb_addr = 32'h04; tb_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        tb_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort ready", 32'(w_ready), 32'd0);
        check("abort busy", 32'(w_busy), 32'd0);
        check("abort read_data", w_rdata, 32'd0);
        rst_n = 1'b1;
        model_reset();
        run_and_check("abort load 04", 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0);
        run_and_check("wiped load 0C", 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0);
        run_and_check("wiped load 10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            logic        rd;
            logic        wr;
            logic [31:0] a;
            logic [31:0] d;
            int          kind;
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            d = $urandom;
            rd = (kind <= 3);
            wr = (kind >= 4 && kind <= 7);
            if (kind == 8) begin
                rd = $urandom_range(0, 1) != 0;
                wr = !rd;
                a = a + 32'($urandom_range(1, 3));
            end else if (kind == 9) begin
                if ($urandom_range(0, 1) != 0) begin
                    rd = 1'b1; wr = 1'b1;
                end else begin
                    rd = 1'b1; wr = 1'b0;
                    a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1000)) * 4);
                end
            end
            model_apply(rd, wr, a, d, exp_err, exp_rd);
            run_and_check($sformatf("rand%0d", i), rd, wr, a, d, exp_err, exp_rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Zero-wait-state instance: back-to-back stores at cycles 1 and 3.
        sel = 1'b1;
        run_and_check("ws0 store 00", 1'b0, 1'b1, 32'h00, 32'hA5A5_0001, 1'b0, 32'h0);
        run_and_check("ws0 store 04", 1'b0, 1'b1, 32'h04, 32'hA5A5_0002, 1'b0, 32'h0);
        run_and_check("ws0 both strobes", 1'b1, 1'b1, 32'h04, 32'hFFFF_FFFF, 1'b1, 32'h0);
        run_and_check("ws0 load 04", 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'hA5A5_0002);
        run_and_check("ws0 load 00", 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 32'hA5A5_0001);
        run_and_check("ws0 misaligned", 1'b1, 1'b0, 32'h02, 32'h0, 1'b1, 32'hA5A5_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
